// File: rtl/supply_domain_sequencer.sv
// Supply domain sequencer: releases pad-ring supply domains one by one on debounced power-good,
// powers down in reverse order, and latches brown-out / ramp-timeout faults with the domain index.
module supply_domain_sequencer #(
  parameter int N_DOMAINS       = 4,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int STEP_CYCLES     = 32,
  parameter int TIMEOUT_CYCLES  = 1024,
  parameter int CNT_W           = 11,
  localparam int IDX_W = (N_DOMAINS > 1) ? $clog2(N_DOMAINS) : 1
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic                 i_start,
  input  logic [N_DOMAINS-1:0] i_pg_async,
  output logic [N_DOMAINS-1:0] o_dom_en,
  output logic                 o_all_good,
  output logic                 o_fault,
  output logic [IDX_W-1:0]     o_fault_domain,
  output logic                 o_busy,
  output logic [2:0]           o_state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_UP    = 3'd1,
    S_ON    = 3'd2,
    S_DOWN  = 3'd3,
    S_FAULT = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] STEP_LAST = CNT_W'(STEP_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(N_DOMAINS - 1);

  logic [N_DOMAINS-1:0] r_pg_meta;
  logic [N_DOMAINS-1:0] r_pg_s;
  logic [N_DOMAINS-1:0] r_pg_db;
  logic [CNT_W-1:0]     r_db_cnt [N_DOMAINS];
  logic [N_DOMAINS-1:0] w_pg_db;

  state_t               r_state, w_state;
  logic                 r_settle, w_settle;
  logic [IDX_W-1:0]     r_idx, w_idx;
  logic [CNT_W-1:0]     r_cnt, w_cnt;
  logic [N_DOMAINS-1:0] r_dom_en, w_dom_en;
  logic                 r_all_good, w_all_good;
  logic                 r_fault, w_fault;
  logic [IDX_W-1:0]     r_fault_domain, w_fault_domain;

  logic [N_DOMAINS-1:0] w_mon;
  logic [N_DOMAINS-1:0] w_bad;
  logic                 w_bad_any;
  logic [IDX_W-1:0]     w_bad_idx;
  logic                 w_go_fault;
  logic [IDX_W-1:0]     w_go_fault_idx;

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_pg_meta <= '0;
      r_pg_s    <= '0;
    end else begin
      r_pg_meta <= i_pg_async;
      r_pg_s    <= r_pg_meta;
    end
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_pg_db <= '0;
      for (int i = 0; i < N_DOMAINS; i++) r_db_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < N_DOMAINS; i++) begin
        if (!r_pg_s[i]) begin
          r_db_cnt[i] <= '0;
          r_pg_db[i]  <= 1'b0;
        end else if (!r_pg_db[i]) begin
          if (r_db_cnt[i] == DB_LAST) r_pg_db[i] <= 1'b1;
          else                        r_db_cnt[i] <= r_db_cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  // Gating with the synced level gives the fast fall without waiting for the register.
  assign w_pg_db = r_pg_db & r_pg_s;

  always_comb begin
    w_mon = '0;
    for (int j = 0; j < N_DOMAINS; j++) begin
      if (r_state == S_ON)
        w_mon[j] = 1'b1;
      else if (r_state == S_UP)
        w_mon[j] = (IDX_W'(j) < r_idx) || ((IDX_W'(j) == r_idx) && r_settle);
    end
    w_bad     = w_mon & ~w_pg_db;
    w_bad_any = |w_bad;
    w_bad_idx = '0;
    for (int j = N_DOMAINS - 1; j >= 0; j--) begin
      if (w_bad[j]) w_bad_idx = IDX_W'(j);
    end
  end

  always_comb begin
    w_state        = r_state;
    w_settle       = r_settle;
    w_idx          = r_idx;
    w_cnt          = r_cnt;
    w_dom_en       = r_dom_en;
    w_all_good     = r_all_good;
    w_fault        = r_fault;
    w_fault_domain = r_fault_domain;
    w_go_fault     = 1'b0;
    w_go_fault_idx = '0;

    unique case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_state     = S_UP;
          w_settle    = 1'b0;
          w_idx       = '0;
          w_cnt       = '0;
          w_dom_en    = '0;
          w_dom_en[0] = 1'b1;
        end
      end
      S_UP: begin
        if (w_bad_any) begin
          w_go_fault     = 1'b1;
          w_go_fault_idx = w_bad_idx;
        end else if (!r_settle && !w_pg_db[r_idx] && (r_cnt == TO_LAST)) begin
          w_go_fault     = 1'b1;
          w_go_fault_idx = r_idx;
        end else if (!i_start) begin
          w_state         = S_DOWN;
          w_settle        = 1'b0;
          w_cnt           = '0;
          w_dom_en[r_idx] = 1'b0;
        end else if (!r_settle) begin
          if (w_pg_db[r_idx]) begin
            w_settle = 1'b1;
            w_cnt    = '0;
          end else begin
            w_cnt = r_cnt + CNT_W'(1);
          end
        end else if (r_cnt == STEP_LAST) begin
          w_settle = 1'b0;
          w_cnt    = '0;
          if (r_idx == IDX_LAST) begin
            w_state    = S_ON;
            w_all_good = 1'b1;
          end else begin
            w_idx           = r_idx + IDX_W'(1);
            w_dom_en[w_idx] = 1'b1;
          end
        end else begin
          w_cnt = r_cnt + CNT_W'(1);
        end
      end
      S_ON: begin
        if (w_bad_any) begin
          w_go_fault     = 1'b1;
          w_go_fault_idx = w_bad_idx;
        end else if (!i_start) begin
          w_state            = S_DOWN;
          w_all_good         = 1'b0;
          w_idx              = IDX_LAST;
          w_cnt              = '0;
          w_dom_en[IDX_LAST] = 1'b0;
        end
      end
      S_DOWN: begin
        // A returning start only takes effect on a step boundary so each step keeps its settle time.
        if (r_cnt == STEP_LAST) begin
          w_cnt = '0;
          if (i_start) begin
            w_state         = S_UP;
            w_settle        = 1'b0;
            w_dom_en[r_idx] = 1'b1;
          end else if (r_idx != '0) begin
            w_idx           = r_idx - IDX_W'(1);
            w_dom_en[w_idx] = 1'b0;
          end else begin
            w_state = S_IDLE;
          end
        end else begin
          w_cnt = r_cnt + CNT_W'(1);
        end
      end
      S_FAULT: begin
        if (!i_start) begin
          w_state        = S_IDLE;
          w_fault        = 1'b0;
          w_fault_domain = '0;
          w_idx          = '0;
          w_cnt          = '0;
        end
      end
      default: begin
        w_state = S_IDLE;
      end
    endcase

    if (w_go_fault) begin
      w_state        = S_FAULT;
      w_dom_en       = '0;
      w_all_good     = 1'b0;
      w_fault        = 1'b1;
      w_fault_domain = w_go_fault_idx;
      w_settle       = 1'b0;
      w_cnt          = '0;
    end
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state        <= S_IDLE;
      r_settle       <= 1'b0;
      r_idx          <= '0;
      r_cnt          <= '0;
      r_dom_en       <= '0;
      r_all_good     <= 1'b0;
      r_fault        <= 1'b0;
      r_fault_domain <= '0;
    end else begin
      r_state        <= w_state;
      r_settle       <= w_settle;
      r_idx          <= w_idx;
      r_cnt          <= w_cnt;
      r_dom_en       <= w_dom_en;
      r_all_good     <= w_all_good;
      r_fault        <= w_fault;
      r_fault_domain <= w_fault_domain;
    end
  end

  assign o_dom_en       = r_dom_en;
  assign o_all_good     = r_all_good;
  assign o_fault        = r_fault;
  assign o_fault_domain = r_fault_domain;
  assign o_busy         = (r_state == S_UP) || (r_state == S_DOWN);
  assign o_state_dbg    = r_state;

endmodule

// File: tb/tb_supply_domain_sequencer.sv
// Bench for supply_domain_sequencer: randomized ramp delays and faults against a timeline model.
module tb_supply_domain_sequencer;
  localparam int D = 4;
  localparam int S = 8;
  localparam int T = 64;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [3:0] pg = 4'h0;
  logic [3:0] dom_en;
  logic       all_good, fault, busy;
  logic [1:0] fd;
  logic [2:0] st;
  int checks = 0;
  int errors = 0;

  supply_domain_sequencer #(
    .N_DOMAINS(4), .DEBOUNCE_CYCLES(D), .STEP_CYCLES(S), .TIMEOUT_CYCLES(T), .CNT_W(11)
  ) dut (
    .i_clock(clk), .i_reset(rst), .i_start(start), .i_pg_async(pg),
    .o_dom_en(dom_en), .o_all_good(all_good), .o_fault(fault),
    .o_fault_domain(fd), .o_busy(busy), .o_state_dbg(st)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic apply_reset();
    start = 1'b0;
    pg    = 4'h0;
    @(negedge clk) rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
  endtask

  // All power-goods already high, so each step takes 1 + S clocks and ON arrives 36 clocks after start.
  task automatic bring_up();
    pg = 4'hF;
    repeat (6) @(posedge clk);
    #1 start = 1'b1;
    repeat (40) @(posedge clk);
    @(negedge clk);
    checks++;
    if (st !== 3'd2 || dom_en !== 4'hF || all_good !== 1'b1) begin
      errors++;
      $display("FAIL bring_up state=%0d dom_en=%b all_good=%b, want 2 1111 1", st, dom_en, all_good);
    end
  endtask

  task automatic test_reset();
    start = 1'b0;
    pg    = 4'h0;
    @(negedge clk) rst = 1'b1;
    #2;
    checks++;
    if ({dom_en, all_good, fault, fd, busy, st} !== 11'd0) begin
      errors++;
      $display("FAIL reset_values got %b want all zero", {dom_en, all_good, fault, fd, busy, st});
    end
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (st !== 3'd0 || dom_en !== 4'h0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_hold state=%0d dom_en=%b busy=%b want 0 0000 0", st, dom_en, busy);
    end
  endtask

  // Power-up scenario. dN: clocks after dom_en[N] rises before pg[N] goes high (-1 = never).
  // glitch_c: 3-clock pg[0] pulse starting then. drop_c/drop_dom: a raised pg falls then.
  task automatic test_power_up(input string name, input int d0, input int d1, input int d2,
                               input int d3, input int glitch_c, input int drop_c,
                               input int drop_dom);
    int dl[4];
    int en[5];
    int on_t, flt_t, flt_dom, last;
    bit hung;
    logic [3:0] exp_en;
    logic [2:0] exp_st;
    logic exp_fault, exp_ag, exp_busy;
    logic [1:0] exp_fd;
    dl[0] = d0; dl[1] = d1; dl[2] = d2; dl[3] = d3;
    en[0] = 0; on_t = -1; flt_t = -1; flt_dom = 0; hung = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (hung) en[k+1] = 32'h3fff_ffff;
      else if (dl[k] < 0) begin
        hung = 1'b1; flt_t = en[k] + T; flt_dom = k; en[k+1] = 32'h3fff_ffff;
      end else en[k+1] = en[k] + dl[k] + 3 + D + S;
    end
    if (!hung) on_t = en[4];
    if (drop_c >= 0 && (flt_t < 0 || drop_c + 3 < flt_t)) begin
      flt_t = drop_c + 3; flt_dom = drop_dom;
    end
    last = ((flt_t >= 0) ? flt_t : on_t) + 4;

    @(posedge clk);
    #1 start = 1'b1;
    for (int c = 0; c <= last; c++) begin
      @(posedge clk);
      #1;
      if (c == glitch_c) pg[0] = 1'b1;
      if (glitch_c >= 0 && c == glitch_c + 3) pg[0] = 1'b0;
      for (int k = 0; k < 4; k++)
        if (dl[k] >= 0 && en[k] < 32'h3fff_ffff && c == en[k] + dl[k]) pg[k] = 1'b1;
      if (c == drop_c) pg[drop_dom] = 1'b0;
      @(negedge clk);
      if (flt_t >= 0 && c >= flt_t) begin
        exp_en = 4'h0; exp_st = 3'd4; exp_fault = 1'b1; exp_fd = 2'(flt_dom); exp_ag = 1'b0;
      end else begin
        exp_en = 4'h0;
        for (int k = 0; k < 4; k++) if (en[k] <= c) exp_en[k] = 1'b1;
        exp_st = (on_t >= 0 && c >= on_t) ? 3'd2 : 3'd1;
        exp_fault = 1'b0; exp_fd = 2'd0; exp_ag = (exp_st == 3'd2);
      end
      exp_busy = (exp_st == 3'd1);
      checks++;
      if (dom_en !== exp_en) begin
        errors++; $display("FAIL %s dom_en c=%0d got %b want %b", name, c, dom_en, exp_en);
      end
      checks++;
      if (st !== exp_st) begin
        errors++; $display("FAIL %s state c=%0d got %0d want %0d", name, c, st, exp_st);
      end
      checks++;
      if (fault !== exp_fault || fd !== exp_fd) begin
        errors++;
        $display("FAIL %s fault c=%0d got %b/%0d want %b/%0d", name, c, fault, fd, exp_fault, exp_fd);
      end
      checks++;
      if (all_good !== exp_ag || busy !== exp_busy) begin
        errors++;
        $display("FAIL %s ag_busy c=%0d got %b%b want %b%b", name, c, all_good, busy, exp_ag, exp_busy);
      end
    end
  endtask

  task automatic test_nominal_up();
    apply_reset();
    test_power_up("nominal_up", 2, 2, 2, 2, -1, -1, 0);
    apply_reset();
    test_power_up("random_up", $urandom_range(0, 6), $urandom_range(0, 6),
                  $urandom_range(0, 6), $urandom_range(0, 6), -1, -1, 0);
  endtask

  task automatic test_timeout();
    int dd[4];
    int hang;
    apply_reset();
    test_power_up("timeout_d2", 2, 2, -1, 2, -1, -1, 0);
    apply_reset();
    hang = $urandom_range(0, 3);
    for (int k = 0; k < 4; k++) dd[k] = (k == hang) ? -1 : $urandom_range(0, 5);
    test_power_up("timeout_rand", dd[0], dd[1], dd[2], dd[3], -1, -1, 0);
  endtask

  task automatic test_glitch();
    int g;
    apply_reset();
    g = $urandom_range(0, 4);
    test_power_up("glitch", g + 3 + $urandom_range(1, 5), 1, 1, 1, g, -1, 0);
  endtask

  // Enables land at 0, 17, 34 with 2-clock ramps; the drop lands once domain 2 is enabled.
  task automatic test_brownout_up();
    apply_reset();
    test_power_up("brownout_up", 2, 2, 2, 2, -1, 34 + $urandom_range(0, 20), $urandom_range(0, 1));
  endtask

  task automatic test_brownout_on();
    logic [3:0] mask;
    logic [1:0] exp_fd;
    for (int r = 0; r < 2; r++) begin
      apply_reset();
      bring_up();
      mask = (r == 0) ? 4'b1010 : 4'($urandom_range(1, 15));
      exp_fd = 2'd3;
      for (int k = 3; k >= 0; k--) if (mask[k]) exp_fd = 2'(k);
      for (int c = 0; c <= 6; c++) begin
        @(posedge clk);
        #1 if (c == 0) pg = pg & ~mask;
        @(negedge clk);
        checks++;
        if (c < 3 ? (st !== 3'd2 || dom_en !== 4'hF || fault !== 1'b0)
                  : (st !== 3'd4 || dom_en !== 4'h0 || fault !== 1'b1 || fd !== exp_fd
                     || all_good !== 1'b0)) begin
          errors++;
          $display("FAIL brownout_on mask=%b c=%0d got st=%0d en=%b f=%b fd=%0d", mask, c, st,
                   dom_en, fault, fd);
        end
      end
      @(posedge clk);
      #1 start = 1'b0;
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (st !== 3'd0 || fault !== 1'b0 || fd !== 2'd0) begin
        errors++;
        $display("FAIL fault_clear got st=%0d fault=%b fd=%0d want 0 0 0", st, fault, fd);
      end
    end
  endtask

  task automatic test_nominal_down();
    int drop_at[4];
    logic [3:0] exp_en;
    logic [2:0] exp_st;
    apply_reset();
    bring_up();
    for (int k = 0; k < 4; k++) drop_at[k] = (3 - k) * S + $urandom_range(1, S - 1);
    @(posedge clk);
    #1 start = 1'b0;
    for (int c = 0; c <= 36; c++) begin
      @(posedge clk);
      #1;
      for (int k = 0; k < 4; k++) if (c == drop_at[k]) pg[k] = 1'b0;
      @(negedge clk);
      if (c < 4 * S) begin
        exp_en = 4'((1 << (3 - c / S)) - 1); exp_st = 3'd3;
      end else begin
        exp_en = 4'h0; exp_st = 3'd0;
      end
      checks++;
      if (dom_en !== exp_en || st !== exp_st || all_good !== 1'b0 || fault !== 1'b0
          || busy !== (exp_st == 3'd3)) begin
        errors++;
        $display("FAIL nominal_down c=%0d got en=%b st=%0d ag=%b f=%b busy=%b want en=%b st=%0d",
                 c, dom_en, st, all_good, fault, busy, exp_en, exp_st);
      end
    end
  endtask

  task automatic test_down_restart();
    int cs, b, ir, on_t;
    logic [3:0] exp_en;
    logic [2:0] exp_st;
    apply_reset();
    bring_up();
    cs = $urandom_range(0, 30);
    b = (cs / S + 1) * S;
    ir = 4 - b / S;
    on_t = b + (1 + S) * (4 - ir);
    @(posedge clk);
    #1 start = 1'b0;
    for (int c = 0; c <= on_t + 3; c++) begin
      @(posedge clk);
      #1 if (c == cs) start = 1'b1;
      @(negedge clk);
      if (c < b) begin
        exp_en = 4'((1 << (3 - c / S)) - 1); exp_st = 3'd3;
      end else begin
        exp_en = 4'((1 << ir) - 1);
        for (int k = ir; k < 4; k++) if (b + (1 + S) * (k - ir) <= c) exp_en[k] = 1'b1;
        exp_st = (c >= on_t) ? 3'd2 : 3'd1;
      end
      checks++;
      if (dom_en !== exp_en || st !== exp_st || all_good !== (exp_st == 3'd2)) begin
        errors++;
        $display("FAIL down_restart cs=%0d c=%0d got en=%b st=%0d want en=%b st=%0d",
                 cs, c, dom_en, st, exp_en, exp_st);
      end
    end
  endtask

  task automatic test_async_reset();
    apply_reset();
    pg = 4'hF;
    repeat (6) @(posedge clk);
    #1 start = 1'b1;
    repeat ($urandom_range(5, 30)) @(posedge clk);
    #3 rst = 1'b1;
    pg = 4'h0;
    #2;
    checks++;
    if (dom_en !== 4'h0 || st !== 3'd0 || busy !== 1'b0 || all_good !== 1'b0) begin
      errors++;
      $display("FAIL async_reset got en=%b st=%0d busy=%b want 0000 0 0", dom_en, st, busy);
    end
    @(posedge clk);
    @(negedge clk) rst = 1'b0;
    pg = 4'hF;
    // pg already high at release: db at F0+1+D, settle from F0+2+D, domain 1 at F0+2+D+S.
    for (int c = 0; c <= 2 + D + S; c++) begin
      @(negedge clk);
      checks++;
      if (dom_en !== ((c < 2 + D + S) ? 4'h1 : 4'h3) || st !== 3'd1) begin
        errors++;
        $display("FAIL async_restart c=%0d got en=%b st=%0d", c, dom_en, st);
      end
    end
  endtask

  initial begin
    test_reset();
    test_nominal_up();
    test_nominal_down();
    test_timeout();
    test_brownout_on();
    test_glitch();
    test_brownout_up();
    test_down_restart();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
